mtip_frame_arb: RTL and testbench
=================================

Name: mtip_frame_arb

Overview:
- Frame-atomic 2:1 round-robin arbiter merging two MTIP RX channel buffers (36-bit show-ahead FIFOs) onto the single Frame Extractor datapath.
- Sequences FIFO reads and never interleaves words of two frames.
- Enforces a programmable minimum inter-packet gap on the merged stream.
- Flushes orphan (non-SOP) words and force-terminates frames whose EOP is missing.

Parameters:
- DEF_IPG, 4'h2, gap applied while iIPG_CNT is 0 (0 treated as 1).
- CNT_W, 16, width of the orphan and abort statistics counters.

Ports:
- iCLK  in  1  212.5 MHz clock
- iRESET_n  in  1  asynchronous, active-low reset
- iCH0_Q  in  36  ch0 FIFO head word: [31:0] data, [32] SOP, [33] EOP, [34] ERR, [35] unused
- iCH0_EMPTY  in  1  ch0 FIFO empty
- oCH0_RDEN  out  1  ch0 pop; head word consumed this cycle
- iCH1_Q / iCH1_EMPTY / oCH1_RDEN  as ch0, for ch1
- iIPG_CNT  in  4  minimum idle cycles between frames; 0 means use DEF_IPG
- oDATA  out  32  merged data; 0 when oDVAL=0
- oSOP / oEOP / oERR  out  1  each qualified by oDVAL
- oDVAL  out  1  output word valid
- oGRANT  out  1  channel owning current or last frame
- oBUSY  out  1  state is not IDLE
- oORPHAN_CNT  out  CNT_W  words flushed in IDLE without SOP; saturating
- oABORT_CNT  out  CNT_W  frames force-terminated; saturating

Behaviour:
- Reset, asynchronous:
  - state IDLE; all outputs 0; round-robin pointer = ch0 (ch0 has priority first); IPG counter 0; statistics counters 0.
  - Reset mid-frame drops the frame with no EOP emitted.
- FIFOs are show-ahead: head word is valid whenever EMPTY=0; RDEN pops it. RDEN is combinational from state and head words, and is never asserted while EMPTY=1.
- Output is registered: a word popped in cycle t appears on oDATA/oSOP/oEOP/oERR with oDVAL=1 in cycle t+1.
- States: IDLE, XFER, IPG.
- IDLE:
  - A channel is a candidate when EMPTY=0 and Q[32]=1.
  - If both are candidates, grant the pointer channel.
  - On grant: pop the SOP word, set oGRANT, toggle the pointer to the other channel, go to XFER. If the SOP word also has EOP set (1-word frame), go straight to IPG.
  - Otherwise, each non-empty channel with Q[32]=0 is popped and discarded (oDVAL stays 0) and oORPHAN_CNT increments. Both channels may flush in the same cycle: +2.
- XFER, granted channel only:
  - EMPTY=1: no pop; bubble on output (oDVAL=0); stay in XFER. No timeout.
  - Head without SOP: pop and forward. If Q[33]=1, load the IPG counter and go to IPG.
  - Head with SOP (missing EOP): do not pop. Next cycle emit oDVAL=1, oEOP=1, oERR=1, oDATA=0. oABORT_CNT increments; go to IPG. The SOP word stays at the head and is arbitrated normally afterwards.
  - The other channel is never popped during XFER.
- IPG:
  - N = iIPG_CNT, or DEF_IPG if iIPG_CNT=0. iIPG_CNT is sampled when the counter loads.
  - Counter loads N on entry and decrements each cycle in IPG; go to IDLE when the counter reads 1.
  - Result: exactly N cycles of oDVAL=0 after the EOP cycle before the next SOP, when data is waiting.
  - No pops occur in IPG.
- oERR is passed through from Q[34] and only has meaning on the EOP word; it is forwarded on any word where it is set.
- Counters saturate at all-ones and never wrap.
- oBUSY = 1 in XFER and IPG.

Decomposition:
- Package mtip_arb_pkg:
  - state localparams (one-hot: IDLE=3'h1, XFER=3'h2, IPG=3'h4);
  - head-word bit indices (SOP_BIT=32, EOP_BIT=33, ERR_BIT=34);
  - default IPG constant.
- Sub-module mtip_ipg_timer: load/decrement counter with a done flag. Reusable by other MTIP datapath blocks.

Test Plan:
- Ch0 only, 4-word frame (SOP w0, EOP w3), iIPG_CNT=2 -> oDVAL high for 4 consecutive cycles starting 1 cycle after the first RDEN; oSOP on word 0, oEOP on word 3; oGRANT=0.
- Both channels each hold two back-to-back 3-word frames, iIPG_CNT=3 -> output order ch0, ch1, ch0, ch1; exactly 3 idle cycles between each EOP and the next SOP; no interleaving.
- Ch0 frame with EMPTY toggling every other cycle mid-frame -> bubbles on oDVAL; data order intact; ch1 SOP waiting is not popped until ch0 EOP + gap.
- Ch1 head holds 2 words without SOP, then a frame -> oCH1_RDEN pops 2 words with no oDVAL; oORPHAN_CNT=2; the frame then passes normally.
- Ch0 frame with SOP, 2 words, then a new SOP -> abort cycle with oEOP=1, oERR=1, oDATA=0; oABORT_CNT=1; new frame emitted after the IPG.
- Assert iRESET_n=0 mid-frame -> all outputs 0 immediately; after release, the next SOP is granted to ch0 first; counters read 0.

Source files
------------

// File: rtl/mtip_arb_pkg.sv
// Shared definitions for the MTIP RX channel arbiter: FSM encoding, head-word fields
// and the inter-packet-gap defaults.
package mtip_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'h1,
    ST_XFER = 3'h2,
    ST_IPG  = 3'h4
  } state_t;

  localparam int WORD_W  = 36;
  localparam int DATA_W  = 32;
  localparam int SOP_BIT = 32;
  localparam int EOP_BIT = 33;
  localparam int ERR_BIT = 34;

  localparam logic [3:0] DEF_IPG_VAL = 4'h2;

  // Effective gap: a programmed 0 selects the default, and a default of 0 still gives 1.
  function automatic logic [3:0] eff_ipg(input logic [3:0] cnt, input logic [3:0] def_val);
    logic [3:0] n;
    n = (cnt != 4'h0) ? cnt : def_val;
    return (n == 4'h0) ? 4'h1 : n;
  endfunction

endpackage

// File: rtl/mtip_ipg_timer.sv
// Load/decrement gap timer; oDONE flags the last cycle of the programmed gap.
module mtip_ipg_timer #(
  parameter int W = 4
) (
  input  logic         iCLK,
  input  logic         iRESET_n,
  input  logic         iLOAD,
  input  logic [W-1:0] iLOAD_VAL,
  input  logic         iDEC,
  output logic         oDONE
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRESET_n) begin
    if (!iRESET_n)                 count <= '0;
    else if (iLOAD)                count <= iLOAD_VAL;
    else if (iDEC && count != '0)  count <= count - W'(1);
  end

  // Treating 0 as done keeps the owner from ever stalling on an unloaded timer.
  assign oDONE = (count <= W'(1));

endmodule

// File: rtl/mtip_frame_arb.sv
// Frame-atomic 2:1 round-robin arbiter merging two show-ahead MTIP RX channel FIFOs,
// with a programmable inter-packet gap, orphan flushing and missing-EOP abort.
module mtip_frame_arb
  import mtip_arb_pkg::*;
#(
  parameter logic [3:0] DEF_IPG = DEF_IPG_VAL,
  parameter int         CNT_W   = 16
) (
  input  logic              iCLK,
  input  logic              iRESET_n,
  input  logic [35:0]       iCH0_Q,
  input  logic              iCH0_EMPTY,
  output logic              oCH0_RDEN,
  input  logic [35:0]       iCH1_Q,
  input  logic              iCH1_EMPTY,
  output logic              oCH1_RDEN,
  input  logic [3:0]        iIPG_CNT,
  output logic [31:0]       oDATA,
  output logic              oSOP,
  output logic              oEOP,
  output logic              oERR,
  output logic              oDVAL,
  output logic              oGRANT,
  output logic              oBUSY,
  output logic [CNT_W-1:0]  oORPHAN_CNT,
  output logic [CNT_W-1:0]  oABORT_CNT
);

  state_t            state, stateNxt;
  logic              ptr;
  logic              grant, grantNxt, grantSet;
  logic              rden0, rden1;
  logic              cand0, cand1;
  logic [35:0]       selQ;
  logic              selEmpty;
  logic              fwdVld, fwdAbort;
  logic [ERR_BIT:0]  fwdWord;
  logic              ipgLoad, ipgDone;
  logic [1:0]        orphanInc;
  logic              abortInc;
  logic [CNT_W:0]    orphanSum, abortSum;
  logic              unused_bits;

  assign unused_bits = ^{iCH0_Q[35], iCH1_Q[35]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stateNxt  = state;
    grantNxt  = grant;
    grantSet  = 1'b0;
    rden0     = 1'b0;
    rden1     = 1'b0;
    fwdVld    = 1'b0;
    fwdAbort  = 1'b0;
    fwdWord   = '0;
    ipgLoad   = 1'b0;
    orphanInc = 2'd0;
    abortInc  = 1'b0;
    cand0     = ~iCH0_EMPTY & iCH0_Q[SOP_BIT];
    cand1     = ~iCH1_EMPTY & iCH1_Q[SOP_BIT];
    selQ      = grant ? iCH1_Q : iCH0_Q;
    selEmpty  = grant ? iCH1_EMPTY : iCH0_EMPTY;

    unique case (state)
      ST_IDLE: begin
        if (cand0 || cand1) begin
          grantNxt = (cand0 && cand1) ? ptr : cand1;
          grantSet = 1'b1;
          rden0    = ~grantNxt;
          rden1    = grantNxt;
          fwdVld   = 1'b1;
          fwdWord  = grantNxt ? iCH1_Q[ERR_BIT:0] : iCH0_Q[ERR_BIT:0];
          if (fwdWord[EOP_BIT]) begin
            ipgLoad  = 1'b1;
            stateNxt = ST_IPG;
          end else begin
            stateNxt = ST_XFER;
          end
        end else begin
          // Any non-empty head here lacks SOP: flush it.
          rden0     = ~iCH0_EMPTY;
          rden1     = ~iCH1_EMPTY;
          orphanInc = {1'b0, ~iCH0_EMPTY} + {1'b0, ~iCH1_EMPTY};
        end
      end
      ST_XFER: begin
        if (!selEmpty) begin
          if (selQ[SOP_BIT]) begin
            // Missing EOP: close the frame without consuming the new SOP.
            fwdVld   = 1'b1;
            fwdAbort = 1'b1;
            abortInc = 1'b1;
            ipgLoad  = 1'b1;
            stateNxt = ST_IPG;
          end else begin
            rden0   = ~grant;
            rden1   = grant;
            fwdVld  = 1'b1;
            fwdWord = selQ[ERR_BIT:0];
            if (selQ[EOP_BIT]) begin
              ipgLoad  = 1'b1;
              stateNxt = ST_IPG;
            end
          end
        end
      end
      ST_IPG: begin
        if (ipgDone) stateNxt = ST_IDLE;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  assign oCH0_RDEN = rden0 & iRESET_n;
  assign oCH1_RDEN = rden1 & iRESET_n;
  assign oBUSY     = (state != ST_IDLE);
  assign oGRANT    = grant;

  assign orphanSum = {1'b0, oORPHAN_CNT} + {{(CNT_W-1){1'b0}}, orphanInc};
  assign abortSum  = {1'b0, oABORT_CNT} + {{CNT_W{1'b0}}, abortInc};

  mtip_ipg_timer #(.W(4)) u_ipg (
    .iCLK      (iCLK),
    .iRESET_n  (iRESET_n),
    .iLOAD     (ipgLoad),
    .iLOAD_VAL (eff_ipg(iIPG_CNT, DEF_IPG)),
    .iDEC      (state == ST_IPG),
    .oDONE     (ipgDone)
  );

  always_ff @(posedge iCLK or negedge iRESET_n) begin
    if (!iRESET_n) begin
      state       <= ST_IDLE;
      ptr         <= 1'b0;
      grant       <= 1'b0;
      oDVAL       <= 1'b0;
      oDATA       <= '0;
      oSOP        <= 1'b0;
      oEOP        <= 1'b0;
      oERR        <= 1'b0;
      oORPHAN_CNT <= '0;
      oABORT_CNT  <= '0;
    end else begin
      state <= stateNxt;
      grant <= grantNxt;
      if (grantSet) ptr <= ~grantNxt;
      oDVAL <= fwdVld;
      oDATA <= fwdAbort ? '0 : fwdWord[DATA_W-1:0];
      oSOP  <= fwdVld & ~fwdAbort & fwdWord[SOP_BIT];
      oEOP  <= fwdVld & (fwdAbort | fwdWord[EOP_BIT]);
      oERR  <= fwdVld & (fwdAbort | fwdWord[ERR_BIT]);
      oORPHAN_CNT <= orphanSum[CNT_W] ? '1 : orphanSum[CNT_W-1:0];
      oABORT_CNT  <= abortSum[CNT_W]  ? '1 : abortSum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_mtip_frame_arb.sv
// Self-checking bench for mtip_frame_arb: queue-backed FIFOs, randomized frames and stalls,
// checked every cycle against a transaction-level reference model.
module tb_mtip_frame_arb;

  localparam int         CNT_W   = 16;
  localparam logic [3:0] DEF_IPG = 4'h2;
  localparam longint     CNT_MAX = (64'd1 << CNT_W) - 1;

  logic              iCLK = 1'b0;
  logic              iRESET_n = 1'b0;
  logic [35:0]       iCH0_Q = '0, iCH1_Q = '0;
  logic              iCH0_EMPTY = 1'b1, iCH1_EMPTY = 1'b1;
  logic              oCH0_RDEN, oCH1_RDEN;
  logic [3:0]        iIPG_CNT = 4'd2;
  logic [31:0]       oDATA;
  logic              oSOP, oEOP, oERR, oDVAL, oGRANT, oBUSY;
  logic [CNT_W-1:0]  oORPHAN_CNT, oABORT_CNT;

  always #5 iCLK = ~iCLK;

  mtip_frame_arb #(.DEF_IPG(DEF_IPG), .CNT_W(CNT_W)) dut (
    .iCLK        (iCLK),
    .iRESET_n    (iRESET_n),
    .iCH0_Q      (iCH0_Q),
    .iCH0_EMPTY  (iCH0_EMPTY),
    .oCH0_RDEN   (oCH0_RDEN),
    .iCH1_Q      (iCH1_Q),
    .iCH1_EMPTY  (iCH1_EMPTY),
    .oCH1_RDEN   (oCH1_RDEN),
    .iIPG_CNT    (iIPG_CNT),
    .oDATA       (oDATA),
    .oSOP        (oSOP),
    .oEOP        (oEOP),
    .oERR        (oERR),
    .oDVAL       (oDVAL),
    .oGRANT      (oGRANT),
    .oBUSY       (oBUSY),
    .oORPHAN_CNT (oORPHAN_CNT),
    .oABORT_CNT  (oABORT_CNT)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
  endtask

  // ---------------- FIFO stand-ins ----------------
  logic [35:0] q0[$];
  logic [35:0] q1[$];
  int          stallMode0 = 0, stallMode1 = 0;   // 0 none, 1 random, 2 every other cycle
  int          cyc = 0;

  task automatic push_word(input int ch, input logic [35:0] w);
    if (ch == 0) q0.push_back(w);
    else         q1.push_back(w);
  endtask

  // A truncated frame omits its EOP; it must be followed by another SOP on the same channel.
  task automatic push_frame(input int ch, input int len, input bit trunc);
    logic [35:0] w;
    bit          eop;
    for (int i = 0; i < len; i++) begin
      eop   = (i == len - 1) && !trunc;
      w     = '0;
      w[31:0] = $urandom();
      w[32] = (i == 0);
      w[33] = eop;
      w[34] = eop && ($urandom_range(0, 3) == 0);
      push_word(ch, w);
    end
  endtask

  task automatic push_orphans(input int ch, input int n);
    logic [35:0] w;
    for (int i = 0; i < n; i++) begin
      w       = '0;
      w[31:0] = $urandom();
      w[33]   = $urandom_range(0, 1);
      w[34]   = $urandom_range(0, 1);
      push_word(ch, w);
    end
  endtask

  function automatic bit stalled(input int mode);
    if (mode == 1) return ($urandom_range(0, 3) == 0);
    if (mode == 2) return (cyc % 2 == 1);
    return 1'b0;
  endfunction

  task automatic drive();
    logic [63:0] junk;
    bit s0, s1;
    s0 = stalled(stallMode0);
    s1 = stalled(stallMode1);
    iCH0_EMPTY = (q0.size() == 0) || s0;
    iCH1_EMPTY = (q1.size() == 0) || s1;
    junk = {$urandom(), $urandom()};
    iCH0_Q = iCH0_EMPTY ? junk[35:0] : q0[0];
    junk = {$urandom(), $urandom()};
    iCH1_Q = iCH1_EMPTY ? junk[35:0] : q1[0];
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_FRAME, M_GAP} mphase_t;
  mphase_t     ph;
  int          owner, gapLeft, ptr, mGrant;
  longint      mOrphan, mAbort;
  bit          eDval, eSop, eEop, eErr;
  logic [31:0] eData;

  task automatic model_reset();
    ph = M_IDLE; owner = 0; gapLeft = 0; ptr = 0; mGrant = 0;
    mOrphan = 0; mAbort = 0;
    eDval = 0; eSop = 0; eEop = 0; eErr = 0; eData = '0;
  endtask

  task automatic start_gap();
    int n;
    n = (iIPG_CNT != 0) ? int'(iIPG_CNT) : ((DEF_IPG != 0) ? int'(DEF_IPG) : 1);
    gapLeft = n;
    ph      = M_GAP;
  endtask

  // Compare current outputs, then advance the model one cycle from the visible FIFO heads.
  task automatic compare_and_step();
    bit          v[2];
    logic [35:0] w[2];
    bit          pop[2];
    bit          nDval, nAbort, c0, c1;
    logic [35:0] nWord;
    int          g;

    check("dval",   oDVAL,  eDval);
    check("data",   oDATA,  eData);
    check("sop",    oSOP,   eSop);
    check("eop",    oEOP,   eEop);
    check("err",    oERR,   eErr);
    check("busy",   oBUSY,  ph != M_IDLE);
    check("grant",  oGRANT, mGrant);
    check("orphan", oORPHAN_CNT, mOrphan);
    check("abort",  oABORT_CNT,  mAbort);

    v[0] = !iCH0_EMPTY; w[0] = iCH0_Q;
    v[1] = !iCH1_EMPTY; w[1] = iCH1_Q;
    pop[0] = 0; pop[1] = 0;
    nDval = 0; nAbort = 0; nWord = '0;

    case (ph)
      M_IDLE: begin
        c0 = v[0] && w[0][32];
        c1 = v[1] && w[1][32];
        if (c0 || c1) begin
          g = (c0 && c1) ? ptr : (c1 ? 1 : 0);
          pop[g] = 1; mGrant = g; ptr = 1 - g;
          nDval = 1; nWord = w[g];
          if (w[g][33]) start_gap();
          else begin ph = M_FRAME; owner = g; end
        end else begin
          for (int c = 0; c < 2; c++)
            if (v[c]) begin
              pop[c] = 1;
              if (mOrphan < CNT_MAX) mOrphan++;
            end
        end
      end
      M_FRAME: begin
        if (v[owner]) begin
          nDval = 1;
          if (w[owner][32]) begin
            nAbort = 1;
            if (mAbort < CNT_MAX) mAbort++;
            start_gap();
          end else begin
            pop[owner] = 1; nWord = w[owner];
            if (w[owner][33]) start_gap();
          end
        end
      end
      default: begin
        gapLeft--;
        if (gapLeft == 0) ph = M_IDLE;
      end
    endcase

    check("rden0", oCH0_RDEN, pop[0]);
    check("rden1", oCH1_RDEN, pop[1]);
    if (pop[0]) void'(q0.pop_front());
    if (pop[1]) void'(q1.pop_front());

    eDval = nDval;
    eData = nAbort ? 32'h0 : nWord[31:0];
    eSop  = nDval && !nAbort && nWord[32];
    eEop  = nDval && (nAbort || nWord[33]);
    eErr  = nDval && (nAbort || nWord[34]);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK);
      #1;
      cyc++;
      drive();
      @(negedge iCLK);
      compare_and_step();
    end
  endtask

  // Run until both FIFOs are drained and the model is idle; an expired budget is a failure.
  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && ph == M_IDLE) && k < budget) begin
      run_cycles(1);
      k++;
    end
    check({tag, "_drained"}, k < budget, 1);
    run_cycles(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dval"},   oDVAL, 0);
    check({tag, "_data"},   oDATA, 0);
    check({tag, "_flags"},  {oSOP, oEOP, oERR}, 0);
    check({tag, "_busy"},   oBUSY, 0);
    check({tag, "_grant"},  oGRANT, 0);
    check({tag, "_rden"},   {oCH0_RDEN, oCH1_RDEN}, 0);
    check({tag, "_cnts"},   {oORPHAN_CNT, oABORT_CNT}, 0);
  endtask

  initial begin
    int k;
    model_reset();
    repeat (3) @(posedge iCLK);
    #1;
    check_all_zero("reset");
    @(negedge iCLK);
    iRESET_n = 1'b1;

    // Single 4-word frame on ch0.
    iIPG_CNT = 4'd2;
    push_frame(0, 4, 0);
    drain("single", 100);

    // Two back-to-back 3-word frames on each channel: must alternate ch0, ch1, ch0, ch1.
    iIPG_CNT = 4'd3;
    push_frame(0, 3, 0); push_frame(0, 3, 0);
    push_frame(1, 3, 0); push_frame(1, 3, 0);
    drain("rr", 200);

    // ch0 stalls every other cycle while ch1 has a frame waiting.
    iIPG_CNT   = 4'd2;
    stallMode0 = 2;
    push_frame(0, 6, 0);
    push_frame(1, 2, 0);
    drain("bubble", 200);
    stallMode0 = 0;

    // Two orphan words ahead of a ch1 frame.
    push_orphans(1, 2);
    push_frame(1, 3, 0);
    drain("orphan", 100);
    check("orphan_total", oORPHAN_CNT, 2);

    // Frame missing its EOP, followed by a fresh SOP on the same channel.
    push_frame(0, 3, 1);
    push_frame(0, 2, 0);
    drain("abort", 100);
    check("abort_total", oABORT_CNT, 1);

    // IPG of 0 selects the default gap.
    iIPG_CNT = 4'd0;
    push_frame(0, 1, 0); push_frame(1, 1, 0); push_frame(0, 2, 0);
    drain("defipg", 100);

    // Reset in the middle of a frame.
    iIPG_CNT = 4'd2;
    push_frame(1, 8, 0);
    k = 0;
    while (ph != M_FRAME && k < 30) begin run_cycles(1); k++; end
    run_cycles(2);
    check("mid_frame_reached", ph == M_FRAME, 1);
    #2 iRESET_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    q0.delete(); q1.delete();
    iCH0_EMPTY = 1'b1; iCH1_EMPTY = 1'b1;
    model_reset();
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRESET_n = 1'b1;
    push_frame(1, 2, 0);
    push_frame(0, 2, 0);
    run_cycles(2);
    check("rst_first_grant", oGRANT, 0);
    check("rst_first_sop",   oSOP, 1);
    drain("post_rst", 100);

    // Randomized traffic with random stalls and gaps.
    stallMode0 = 1; stallMode1 = 1;
    for (int b = 0; b < 40; b++) begin
      iIPG_CNT = 4'($urandom_range(0, 5));
      for (int ch = 0; ch < 2; ch++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          if ($urandom_range(0, 4) == 0) push_orphans(ch, $urandom_range(1, 2));
          push_frame(ch, $urandom_range(1, 6), (f < nf - 1) && ($urandom_range(0, 4) == 0));
          // A truncated frame must be closed by the SOP that follows it directly.
          while ((ch == 0 ? q0[q0.size()-1][33] : q1[q1.size()-1][33]) == 1'b0)
            push_frame(ch, $urandom_range(1, 4), 0);
        end
      end
      drain("rand", 1500);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
